// File: rtl/adc16dv160_stream_checker.sv
`default_nettype none
// ============================================================================
// Module : adc16dv160_stream_checker
// Brief  : AXI-Stream sink that checks packet length, TKEEP and the
//          descending test-counter pattern, with status counters and
//          first-mismatch capture.
// Rev    : 1.0  initial release
// ============================================================================
module adc16dv160_stream_checker #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 s00_axis_aclk,
  input  logic                 s00_axis_areset,
  input  logic                 s00_axis_tvalid,
  input  logic [31:0]          s00_axis_tdata,
  input  logic [3:0]           s00_axis_tkeep,
  input  logic                 s00_axis_tlast,
  output logic                 s00_axis_tready,
  input  logic [31:0]          dsize,
  input  logic                 test,
  input  logic                 enable,
  input  logic                 stall,
  input  logic                 clear,
  output logic                 busy,
  output logic                 pc,
  output logic [31:0]          pkt_count,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 sr_len_err,
  output logic                 sr_data_err,
  output logic                 sr_keep_err,
  output logic [31:0]          err_data,
  output logic [31:0]          err_expected,
  output logic [31:0]          err_index
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                 state_q;
  logic [31:0]            len_q;
  logic [31:0]            idx_q;
  logic                   tst_q;
  logic                   pc_q;
  logic                   busy_q;
  logic                   cap_q;
  logic [31:0]            pkt_count_q;
  logic [ERR_CNT_W-1:0]   err_count_q;
  logic                   len_err_q;
  logic                   data_err_q;
  logic                   keep_err_q;
  logic [31:0]            err_data_q;
  logic [31:0]            err_expected_q;
  logic [31:0]            err_index_q;

  logic                   beat;
  logic                   chk_d;
  logic [31:0]            len_d;
  logic [31:0]            idx_d;
  logic                   tst_d;
  logic [31:0]            exp_d;
  logic                   keep_err_d;
  logic                   data_err_d;
  logic                   short_err_d;
  logic                   long_err_d;
  logic                   err_beat_d;
  logic                   pkt_end_d;
  state_t                 end_state_d;

  assign s00_axis_tready = (state_q != ST_IDLE) && !stall;
  assign beat            = s00_axis_tvalid && s00_axis_tready;

  // The first beat is checked against the live dsize/test, later beats against the latched copies.
  always_comb begin
    chk_d       = beat && ((state_q == ST_WAIT) || (state_q == ST_RUN));
    len_d       = (state_q == ST_WAIT) ? dsize : len_q;
    tst_d       = (state_q == ST_WAIT) ? test  : tst_q;
    idx_d       = (state_q == ST_WAIT) ? 32'd0 : idx_q;
    exp_d       = len_d - idx_d;
    keep_err_d  = chk_d && (s00_axis_tkeep != 4'hF);
    data_err_d  = chk_d && tst_d && (s00_axis_tdata != exp_d);
    short_err_d = chk_d && s00_axis_tlast && (idx_d < len_d);
    long_err_d  = chk_d && !s00_axis_tlast && (idx_d == len_d);
    err_beat_d  = keep_err_d || data_err_d || short_err_d || long_err_d;
    pkt_end_d   = beat && s00_axis_tlast;
    end_state_d = enable ? ST_WAIT : ST_IDLE;
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state_q        <= ST_IDLE;
      len_q          <= 32'd0;
      idx_q          <= 32'd0;
      tst_q          <= 1'b0;
      pc_q           <= 1'b0;
      busy_q         <= 1'b0;
      cap_q          <= 1'b0;
      pkt_count_q    <= 32'd0;
      err_count_q    <= '0;
      len_err_q      <= 1'b0;
      data_err_q     <= 1'b0;
      keep_err_q     <= 1'b0;
      err_data_q     <= 32'd0;
      err_expected_q <= 32'd0;
      err_index_q    <= 32'd0;
    end else begin
      pc_q <= pkt_end_d;
      case (state_q)
        ST_IDLE: begin
          if (enable) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (beat) begin
            len_q <= dsize;
            tst_q <= test;
            idx_q <= 32'd1;
            if (s00_axis_tlast)  state_q <= end_state_d;
            else if (long_err_d) state_q <= ST_DRAIN;
            else                 state_q <= ST_RUN;
          end else if (!enable) begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (beat) begin
            idx_q <= idx_q + 32'd1;
            if (s00_axis_tlast)  state_q <= end_state_d;
            else if (long_err_d) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pkt_end_d) state_q <= end_state_d;
        end
        default: state_q <= ST_IDLE;
      endcase

      // busy mirrors the next state so it is a registered output aligned with state_q.
      busy_q <= 1'b0;
      if (state_q == ST_WAIT && beat && !s00_axis_tlast) busy_q <= 1'b1;
      if ((state_q == ST_RUN || state_q == ST_DRAIN) && !pkt_end_d) busy_q <= 1'b1;

      if (clear) begin
        cap_q          <= 1'b0;
        pkt_count_q    <= 32'd0;
        err_count_q    <= '0;
        len_err_q      <= 1'b0;
        data_err_q     <= 1'b0;
        keep_err_q     <= 1'b0;
        err_data_q     <= 32'd0;
        err_expected_q <= 32'd0;
        err_index_q    <= 32'd0;
      end else begin
        if (pkt_end_d) pkt_count_q <= pkt_count_q + 32'd1;
        if (err_beat_d && (err_count_q != '1)) err_count_q <= err_count_q + ERR_CNT_W'(1);
        if (short_err_d || long_err_d) len_err_q  <= 1'b1;
        if (data_err_d)                data_err_q <= 1'b1;
        if (keep_err_d)                keep_err_q <= 1'b1;
        if (data_err_d && !cap_q) begin
          cap_q          <= 1'b1;
          err_data_q     <= s00_axis_tdata;
          err_expected_q <= exp_d;
          err_index_q    <= idx_d;
        end
      end
    end
  end

  assign busy         = busy_q;
  assign pc           = pc_q;
  assign pkt_count    = pkt_count_q;
  assign err_count    = err_count_q;
  assign sr_len_err   = len_err_q;
  assign sr_data_err  = data_err_q;
  assign sr_keep_err  = keep_err_q;
  assign err_data     = err_data_q;
  assign err_expected = err_expected_q;
  assign err_index    = err_index_q;

endmodule
`default_nettype wire
